// File: rtl/ctrl_bubble_stage.sv
// Decode->execute control register with stall, flush and load-use bubbles.
// Optional saturating bubble counter when BUBBLE_STATS_EN is defined.
module ctrl_bubble_stage #(
    parameter int unsigned       CTRL_W        = 8,
    parameter int unsigned       BUBBLE_CYCLES = 1,
    parameter logic [CTRL_W-1:0] KILL_MASK     = {CTRL_W{1'b1}},
    parameter int unsigned       STAT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              hazard,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              valid_out,
    output logic              hold_upstream,
    output logic [STAT_W-1:0] bubble_cnt
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam logic [3:0] REMAIN_INIT = 4'(BUBBLE_CYCLES - 1);

    state_t            state;
    state_t            stateNext;
    logic [3:0]        remain;
    logic [3:0]        remainNext;
    logic [CTRL_W-1:0] ctrlNext;
    logic              validNext;
    logic [CTRL_W-1:0] bubbleVal;
    logic              loadBubble;

    logic doFlush;
    logic doHold;
    logic doStep;
    logic doAccept;
    logic doLoad;

    assign bubbleVal = ctrl_in & ~KILL_MASK;

    // Exactly one action per edge; flush > stall > bubble > load.
    assign doFlush  = flush;
    assign doHold   = ~flush & stall;
    assign doStep   = ~flush & ~stall & (state == BUBBLE);
    assign doAccept = ~flush & ~stall & (state == IDLE) & hazard;
    assign doLoad   = ~flush & ~stall & (state == IDLE) & ~hazard;

    always_comb begin
        stateNext  = state;
        remainNext = remain;
        ctrlNext   = ctrl_out;
        validNext  = valid_out;
        loadBubble = 1'b0;
        unique case (1'b1)
            doFlush: begin
                ctrlNext   = bubbleVal;
                validNext  = 1'b0;
                stateNext  = IDLE;
                remainNext = 4'd0;
            end
            doHold: begin
            end
            doStep: begin
                ctrlNext   = bubbleVal;
                validNext  = 1'b0;
                loadBubble = 1'b1;
                remainNext = (remain == 4'd0) ? 4'd0 : remain - 4'd1;
                if (remain <= 4'd1) begin
                    stateNext = IDLE;
                end
            end
            doAccept: begin
                ctrlNext   = bubbleVal;
                validNext  = 1'b0;
                loadBubble = 1'b1;
                remainNext = REMAIN_INIT;
                stateNext  = (REMAIN_INIT != 4'd0) ? BUBBLE : IDLE;
            end
            doLoad: begin
                ctrlNext  = ctrl_in;
                validNext = valid_in;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remain    <= 4'd0;
            ctrl_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= stateNext;
            remain    <= remainNext;
            ctrl_out  <= ctrlNext;
            valid_out <= validNext;
        end
    end

    // Upstream already obeys stall directly, so stall alone does not hold it.
    assign hold_upstream = ~flush
        & ((state == BUBBLE) | ((state == IDLE) & hazard & ~stall));

`ifdef BUBBLE_STATS_EN
    logic [STAT_W-1:0] statCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            statCnt <= '0;
        end else if (loadBubble && (statCnt != {STAT_W{1'b1}})) begin
            statCnt <= statCnt + 1'b1;
        end
    end

    assign bubble_cnt = statCnt;
`else
    logic unusedStat;
    assign unusedStat = loadBubble;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Directed bench for ctrl_bubble_stage: load, hazard, stall, flush,
// async reset and partial kill mask (second instance, mask 8'h0F).
module tb_ctrl_bubble_stage;

    logic       clock;
    logic       reset;
    logic [7:0] ctrlIn;
    logic       validIn;
    logic       stall;
    logic       flush;
    logic       hazard;

    logic [7:0]  ctrlOut;
    logic        validOut;
    logic        holdUp;
    logic [15:0] bubbleCnt;

    logic [7:0]  ctrlOutM;
    logic        validOutM;
    logic        holdUpM;
    logic [15:0] bubbleCntM;

    int nChecks = 0;
    int nErrors = 0;

`ifdef BUBBLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    ctrl_bubble_stage #(
        .CTRL_W(8),
        .BUBBLE_CYCLES(2),
        .STAT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_in(ctrlIn),
        .valid_in(validIn),
        .stall(stall),
        .flush(flush),
        .hazard(hazard),
        .ctrl_out(ctrlOut),
        .valid_out(validOut),
        .hold_upstream(holdUp),
        .bubble_cnt(bubbleCnt)
    );

    ctrl_bubble_stage #(
        .CTRL_W(8),
        .BUBBLE_CYCLES(2),
        .KILL_MASK(8'h0F),
        .STAT_W(16)
    ) dutM (
        .clock(clock),
        .reset(reset),
        .ctrl_in(ctrlIn),
        .valid_in(validIn),
        .stall(stall),
        .flush(flush),
        .hazard(hazard),
        .ctrl_out(ctrlOutM),
        .valid_out(validOutM),
        .hold_upstream(holdUpM),
        .bubble_cnt(bubbleCntM)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] cntExp(input int n);
        return STATS ? n : 0;
    endfunction

    initial begin
        reset   = 1'b1;
        ctrlIn  = 8'h00;
        validIn = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        hazard  = 1'b0;

        #3;
        check("rst_ctrl", ctrlOut, 8'h00);
        check("rst_valid", validOut, 1'b0);
        check("rst_hold", holdUp, 1'b0);
        check("rst_cnt", bubbleCnt, 0);
        step();
        step();
        #3 reset = 1'b0;

        // Plain load
        ctrlIn  = 8'h3C;
        validIn = 1'b1;
        #1 check("load_hold_pre", holdUp, 1'b0);
        step();
        check("load_ctrl", ctrlOut, 8'h3C);
        check("load_valid", validOut, 1'b1);
        check("load_hold", holdUp, 1'b0);

        // One-cycle hazard pulse, two bubbles
        ctrlIn = 8'h5A;
        hazard = 1'b1;
        #1 check("hz_hold_req", holdUp, 1'b1);
        step();
        hazard = 1'b0;
        #1;
        check("hz_e1_ctrl", ctrlOut, 8'h00);
        check("hz_e1_valid", validOut, 1'b0);
        check("hz_e1_hold", holdUp, 1'b1);
        check("hz_e1_maskctrl", ctrlOutM, 8'h50);
        step();
        check("hz_e2_ctrl", ctrlOut, 8'h00);
        check("hz_e2_valid", validOut, 1'b0);
        step();
        check("hz_e3_ctrl", ctrlOut, 8'h5A);
        check("hz_e3_valid", validOut, 1'b1);
        check("hz_e3_cnt", bubbleCnt, cntExp(2));
        check("hz_e3_hold", holdUp, 1'b0);

        // Stall for 3 cycles after bubble #1
        hazard = 1'b1;
        step();
        hazard = 1'b0;
        stall  = 1'b1;
        #1 check("st_b1_ctrl", ctrlOut, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_ctrl", ctrlOut, 8'h00);
            check("st_valid", validOut, 1'b0);
            check("st_hold", holdUp, 1'b1);
        end
        stall = 1'b0;
        step();
        check("st_b2_ctrl", ctrlOut, 8'h00);
        check("st_b2_valid", validOut, 1'b0);
        step();
        check("st_out_ctrl", ctrlOut, 8'h5A);
        check("st_out_valid", validOut, 1'b1);
        check("st_cnt", bubbleCnt, cntExp(4));

        // Flush after bubble #1
        hazard = 1'b1;
        step();
        hazard = 1'b0;
        flush  = 1'b1;
        #1 check("fl_hold_during", holdUp, 1'b0);
        step();
        flush = 1'b0;
        #1;
        check("fl_ctrl", ctrlOut, 8'h00);
        check("fl_valid", validOut, 1'b0);
        check("fl_hold_after", holdUp, 1'b0);
        ctrlIn = 8'h3C;
        step();
        check("fl_next_ctrl", ctrlOut, 8'h3C);
        check("fl_next_valid", validOut, 1'b1);
        check("fl_cnt", bubbleCnt, cntExp(5));

        // Async reset in the middle of a bubble sequence
        ctrlIn = 8'hA5;
        step();
        check("ar_load_ctrl", ctrlOut, 8'hA5);
        check("ar_load_maskctrl", ctrlOutM, 8'hA5);
        hazard = 1'b1;
        step();
        hazard = 1'b0;
        #1;
        check("ar_bub_hold", holdUp, 1'b1);
        check("ar_bub_maskctrl", ctrlOutM, 8'hA0);
        reset = 1'b1;
        #1;
        check("ar_ctrl", ctrlOut, 8'h00);
        check("ar_maskctrl", ctrlOutM, 8'h00);
        check("ar_valid", validOut, 1'b0);
        check("ar_hold", holdUp, 1'b0);
        check("ar_cnt", bubbleCnt, 0);
        #2 reset = 1'b0;
        step();
        check("ar_rel_ctrl", ctrlOut, 8'hA5);

        // Partial kill mask keeps the upper nibble
        ctrlIn = 8'hF3;
        hazard = 1'b1;
        step();
        hazard = 1'b0;
        #1;
        check("mk_b1_ctrl", ctrlOutM, 8'hF0);
        check("mk_b1_valid", validOutM, 1'b0);
        check("mk_b1_dflt", ctrlOut, 8'h00);
        step();
        check("mk_b2_ctrl", ctrlOutM, 8'hF0);
        check("mk_b2_valid", validOutM, 1'b0);
        step();
        check("mk_out_ctrl", ctrlOutM, 8'hF3);
        check("mk_out_valid", validOutM, 1'b1);
        check("mk_cnt", bubbleCntM, cntExp(2));

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

endmodule
